// File: rtl/uart_rx_push_if.sv
// FIFO write-port bundle between the UART receiver (master) and the byte FIFO (slave).
interface uart_rx_push_if;
  logic       w_en;
  logic [7:0] wr_data;
  logic       q_full;

  modport master (output w_en, output wr_data, input q_full);
  modport slave  (input w_en, input wr_data, output q_full);
endinterface

// File: rtl/uart_rx_push.sv
// 8N1 UART receiver that pushes each good byte into a downstream FIFO.
// Overrun and framing errors are reported through sticky flags.
module uart_rx_push #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX,
  input  logic                  clr_err,
  uart_rx_push_if.master        fifo,
  output logic                  rx_busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV + 1);

  localparam logic [CNT_W-1:0] BAUD_LD = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           state_q;
  logic             sync1_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_q;
  logic [7:0]       shift_q;
  logic             w_en_q;
  logic [7:0]       wr_data_q;
  logic             busy_q, ovr_q, fe_q;
  logic             tick;

  // The sample fires on the cycle the count would reach zero, so a load of N
  // gives a spacing of exactly N cycles between samples.
  assign tick = (cnt_q <= CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      w_en_q    <= 1'b0;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      sync1_q <= RX;
      rx_s_q  <= sync1_q;
      w_en_q  <= 1'b0;
      // Set events later in this block override the clear.
      if (clr_err) begin
        ovr_q <= 1'b0;
        fe_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            cnt_q   <= HALF_LD;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s_q) begin
              cnt_q   <= BAUD_LD;
              bit_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= BAUD_LD;
            bit_q   <= bit_q + 4'd1;
            if (bit_q == 4'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (fifo.q_full) begin
                ovr_q <= 1'b1;
              end else begin
                w_en_q    <= 1'b1;
                wr_data_q <= shift_q;
              end
            end else begin
              fe_q    <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.w_en    = w_en_q;
  assign fifo.wr_data = wr_data_q;
  assign rx_busy      = busy_q;
  assign overrun      = ovr_q;
  assign frame_err    = fe_q;

endmodule
